// File: rtl/pipe_mem_arbiter.sv
// Shares one downstream memory port among NUM_CH requesters, one transaction at a time,
// with round-robin or fixed-priority arbitration and an optional BUSY watchdog.
module pipe_mem_arbiter #(
    parameter int NUM_CH  = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int RR      = 1,
    parameter int TIMEOUT = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_CH-1:0]              ch_read,
    input  logic [NUM_CH-1:0]              ch_write,
    input  logic [NUM_CH*ADDR_W-1:0]       ch_address,
    input  logic [NUM_CH*DATA_W-1:0]       ch_wdata,
    input  logic [NUM_CH*(DATA_W/8)-1:0]   ch_byte_enable,
    output logic [NUM_CH-1:0]              ch_resp,
    output logic [DATA_W-1:0]              ch_rdata,
    output logic                           mem_read,
    output logic                           mem_write,
    output logic [ADDR_W-1:0]              mem_address,
    output logic [DATA_W-1:0]              mem_wdata,
    output logic [DATA_W/8-1:0]            mem_byte_enable,
    input  logic                           mem_resp,
    input  logic [DATA_W-1:0]              mem_rdata,
    output logic                           timeout_err
);

    localparam int BE_W  = DATA_W / 8;
    localparam int PTR_W = $clog2(NUM_CH);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    g_q, g_d;
    logic [PTR_W-1:0]    p_q, p_d;
    logic [CNT_W-1:0]    wdog_q, wdog_d;
    logic                mem_read_q, mem_read_d;
    logic                mem_write_q, mem_write_d;
    logic [ADDR_W-1:0]   mem_address_q, mem_address_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [BE_W-1:0]     mem_be_q, mem_be_d;
    logic [NUM_CH-1:0]   ch_resp_q, ch_resp_d;
    logic [DATA_W-1:0]   ch_rdata_q, ch_rdata_d;
    logic                timeout_err_q, timeout_err_d;

    logic [NUM_CH-1:0]   req_s;
    logic [PTR_W-1:0]    base_s;
    logic [PTR_W-1:0]    gnt_s;
    logic                found_s;

    // Channel index base+off, wrapped modulo NUM_CH (off is always below NUM_CH).
    function automatic logic [PTR_W-1:0] rot_idx(input logic [PTR_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        sum = (sum >= NUM_CH) ? sum - NUM_CH : sum;
        return PTR_W'(sum);
    endfunction

    assign req_s  = ch_read | ch_write;
    assign base_s = (RR != 0) ? p_q : {PTR_W{1'b0}};

    // Priority search starting at base_s: first requesting channel wins.
    always_comb begin
        gnt_s   = {PTR_W{1'b0}};
        found_s = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!found_s && req_s[rot_idx(base_s, i)]) begin
                found_s = 1'b1;
                gnt_s   = rot_idx(base_s, i);
            end else begin
                found_s = found_s;
            end
        end
    end

    // Next-state and next-output computation for the IDLE/BUSY/DONE sequence.
    always_comb begin
        state_d       = state_q;
        g_d           = g_q;
        p_d           = p_q;
        wdog_d        = wdog_q;
        mem_read_d    = mem_read_q;
        mem_write_d   = mem_write_q;
        mem_address_d = mem_address_q;
        mem_wdata_d   = mem_wdata_q;
        mem_be_d      = mem_be_q;
        ch_resp_d     = {NUM_CH{1'b0}};
        ch_rdata_d    = {DATA_W{1'b0}};
        timeout_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (found_s) begin
                    state_d       = ST_BUSY;
                    g_d           = gnt_s;
                    wdog_d        = {CNT_W{1'b0}};
                    mem_write_d   = ch_write[gnt_s];
                    mem_read_d    = ~ch_write[gnt_s];
                    mem_address_d = ch_address[int'(gnt_s)*ADDR_W +: ADDR_W];
                    mem_wdata_d   = ch_wdata[int'(gnt_s)*DATA_W +: DATA_W];
                    mem_be_d      = ch_byte_enable[int'(gnt_s)*BE_W +: BE_W];
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                // mem_resp is checked first so it wins over a coinciding watchdog expiry
                if (mem_resp || ((TIMEOUT > 0) && (wdog_q == WD_LAST))) begin
                    state_d          = ST_DONE;
                    ch_resp_d[g_q]   = 1'b1;
                    ch_rdata_d       = (mem_resp && !mem_write_q) ? mem_rdata : {DATA_W{1'b0}};
                    timeout_err_d    = ~mem_resp;
                    mem_read_d       = 1'b0;
                    mem_write_d      = 1'b0;
                    mem_address_d    = {ADDR_W{1'b0}};
                    mem_wdata_d      = {DATA_W{1'b0}};
                    mem_be_d         = {BE_W{1'b0}};
                    p_d              = (RR != 0) ? rot_idx(g_q, 1) : p_q;
                end else if (TIMEOUT > 0) begin
                    wdog_d = wdog_q + CNT_W'(1);
                end else begin
                    wdog_d = wdog_q;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset clears everything and drops any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            g_q           <= {PTR_W{1'b0}};
            p_q           <= {PTR_W{1'b0}};
            wdog_q        <= {CNT_W{1'b0}};
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_address_q <= {ADDR_W{1'b0}};
            mem_wdata_q   <= {DATA_W{1'b0}};
            mem_be_q      <= {BE_W{1'b0}};
            ch_resp_q     <= {NUM_CH{1'b0}};
            ch_rdata_q    <= {DATA_W{1'b0}};
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            g_q           <= g_d;
            p_q           <= p_d;
            wdog_q        <= wdog_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            mem_address_q <= mem_address_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_be_q      <= mem_be_d;
            ch_resp_q     <= ch_resp_d;
            ch_rdata_q    <= ch_rdata_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign ch_resp         = ch_resp_q;
    assign ch_rdata        = ch_rdata_q;
    assign mem_read        = mem_read_q;
    assign mem_write       = mem_write_q;
    assign mem_address     = mem_address_q;
    assign mem_wdata       = mem_wdata_q;
    assign mem_byte_enable = mem_be_q;
    assign timeout_err     = timeout_err_q;

endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// Directed bench: dut_a is 2-channel round-robin with a 4-cycle watchdog,
// dut_b is 4-channel fixed priority without watchdog.
module tb_pipe_mem_arbiter;

    logic clk;
    logic rst;

    logic [1:0]   ch_read_a, ch_write_a, ch_resp_a;
    logic [63:0]  ch_address_a, ch_wdata_a;
    logic [7:0]   ch_be_a;
    logic [31:0]  ch_rdata_a, mem_address_a, mem_wdata_a, mem_rdata_a;
    logic [3:0]   mem_be_a;
    logic         mem_read_a, mem_write_a, mem_resp_a, tout_a;

    logic [3:0]   ch_read_b, ch_write_b, ch_resp_b;
    logic [127:0] ch_address_b, ch_wdata_b;
    logic [15:0]  ch_be_b;
    logic [31:0]  ch_rdata_b, mem_address_b, mem_wdata_b, mem_rdata_b;
    logic [3:0]   mem_be_b;
    logic         mem_read_b, mem_write_b, mem_resp_b, tout_b;

    int checks = 0;
    int errors = 0;

    pipe_mem_arbiter #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32), .RR(1), .TIMEOUT(4)) dut_a (
        .clk(clk), .rst(rst),
        .ch_read(ch_read_a), .ch_write(ch_write_a), .ch_address(ch_address_a),
        .ch_wdata(ch_wdata_a), .ch_byte_enable(ch_be_a),
        .ch_resp(ch_resp_a), .ch_rdata(ch_rdata_a),
        .mem_read(mem_read_a), .mem_write(mem_write_a), .mem_address(mem_address_a),
        .mem_wdata(mem_wdata_a), .mem_byte_enable(mem_be_a),
        .mem_resp(mem_resp_a), .mem_rdata(mem_rdata_a), .timeout_err(tout_a)
    );

    pipe_mem_arbiter #(.NUM_CH(4), .ADDR_W(32), .DATA_W(32), .RR(0), .TIMEOUT(0)) dut_b (
        .clk(clk), .rst(rst),
        .ch_read(ch_read_b), .ch_write(ch_write_b), .ch_address(ch_address_b),
        .ch_wdata(ch_wdata_b), .ch_byte_enable(ch_be_b),
        .ch_resp(ch_resp_b), .ch_rdata(ch_rdata_b),
        .mem_read(mem_read_b), .mem_write(mem_write_b), .mem_address(mem_address_b),
        .mem_wdata(mem_wdata_b), .mem_byte_enable(mem_be_b),
        .mem_resp(mem_resp_b), .mem_rdata(mem_rdata_b), .timeout_err(tout_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          ch;
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          lat;        // BUSY cycle carrying mem_resp; 0 = never
        logic [31:0] mrdata;
        logic [1:0]  exp_strobe; // {mem_read, mem_write}
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
        bit          exp_tout;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] outs_a();
        return {23'd0, ch_resp_a, ch_rdata_a, mem_read_a, mem_write_a, mem_address_a,
                mem_wdata_a, mem_be_a, tout_a};
    endfunction

    task automatic wait_strobe_a(input string name);
        int n = 0;
        @(negedge clk);
        while (!(mem_read_a || mem_write_a) && n < 8) begin
            @(negedge clk);
            n++;
        end
        check({name, " strobe"}, {127'd0, mem_read_a | mem_write_a}, 128'd1);
    endtask

    task automatic wait_strobe_b(input string name);
        int n = 0;
        @(negedge clk);
        while (!(mem_read_b || mem_write_b) && n < 8) begin
            @(negedge clk);
            n++;
        end
        check({name, " strobe"}, {127'd0, mem_read_b | mem_write_b}, 128'd1);
    endtask

    // Single transaction on dut_a; ch_* data fields are scrambled during BUSY.
    task automatic run_vec(input vec_t v, input int idx);
        int nbusy;
        nbusy = (v.lat == 0) ? 4 : v.lat;
        ch_read_a[v.ch]            = v.rd;
        ch_write_a[v.ch]           = v.wr;
        ch_address_a[v.ch*32 +: 32] = v.addr;
        ch_wdata_a[v.ch*32 +: 32]   = v.wdata;
        ch_be_a[v.ch*4 +: 4]        = v.be;
        mem_rdata_a                 = v.mrdata;
        for (int j = 1; j <= nbusy; j++) begin
            @(negedge clk);
            check($sformatf("v%0d c%0d strobe", idx, j), {126'd0, mem_read_a, mem_write_a}, {126'd0, v.exp_strobe});
            check($sformatf("v%0d c%0d addr", idx, j), {96'd0, mem_address_a}, {96'd0, v.addr});
            check($sformatf("v%0d c%0d wdata", idx, j), {96'd0, mem_wdata_a}, {96'd0, v.wdata});
            check($sformatf("v%0d c%0d be", idx, j), {124'd0, mem_be_a}, {124'd0, v.be});
            ch_address_a[v.ch*32 +: 32] = v.addr ^ 32'hFFFF_0000;
            ch_wdata_a[v.ch*32 +: 32]   = v.wdata ^ 32'h0F0F_0F0F;
            ch_be_a[v.ch*4 +: 4]        = ~v.be;
            mem_resp_a                  = (j == v.lat);
        end
        @(negedge clk);
        mem_resp_a = 1'b0;
        check($sformatf("v%0d resp", idx), {126'd0, ch_resp_a}, {126'd0, v.exp_resp});
        check($sformatf("v%0d rdata", idx), {96'd0, ch_rdata_a}, {96'd0, v.exp_rdata});
        check($sformatf("v%0d tout", idx), {127'd0, tout_a}, {127'd0, v.exp_tout});
        check($sformatf("v%0d strobe off", idx), {126'd0, mem_read_a, mem_write_a}, 128'd0);
        ch_read_a = 2'b00; ch_write_a = 2'b00; ch_address_a = 64'd0; ch_wdata_a = 64'd0; ch_be_a = 8'd0;
        @(negedge clk);
        check($sformatf("v%0d idle", idx), outs_a(), 128'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global time limit reached");
        $fatal(1);
    end

    initial begin
        logic [1:0] rr_exp [4];
        int cnt0, cnt1;

        //        ch rd    wr    addr          wdata         be     lat mrdata        strobe resp   rdata         tout
        vecs[0] = '{0, 1'b1, 1'b0, 32'h0000_0100, 32'h0000_0000, 4'hF, 1, 32'hDEAD_BEEF, 2'b10, 2'b01, 32'hDEAD_BEEF, 1'b0};
        vecs[1] = '{1, 1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678, 4'h3, 3, 32'hAAAA_5555, 2'b01, 2'b10, 32'h0000_0000, 1'b0};
        vecs[2] = '{0, 1'b0, 1'b1, 32'h0000_0044, 32'hCAFE_F00D, 4'hC, 2, 32'h1111_1111, 2'b01, 2'b01, 32'h0000_0000, 1'b0};
        vecs[3] = '{1, 1'b1, 1'b0, 32'h0000_0300, 32'h0000_0000, 4'hF, 0, 32'h5555_5555, 2'b10, 2'b10, 32'h0000_0000, 1'b1};
        vecs[4] = '{0, 1'b1, 1'b0, 32'h0000_0008, 32'h0000_0000, 4'hF, 4, 32'h0BAD_F00D, 2'b10, 2'b01, 32'h0BAD_F00D, 1'b0};
        vecs[5] = '{0, 1'b0, 1'b1, 32'h0000_0010, 32'h0000_0001, 4'h1, 0, 32'h7777_7777, 2'b01, 2'b01, 32'h0000_0000, 1'b1};
        vecs[6] = '{1, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 4'hF, 2, 32'hFFFF_FFFF, 2'b10, 2'b10, 32'hFFFF_FFFF, 1'b0};
        rr_exp = '{2'b01, 2'b10, 2'b01, 2'b10};

        rst = 1'b1;
        ch_read_a = 2'b00; ch_write_a = 2'b00; ch_address_a = 64'd0; ch_wdata_a = 64'd0; ch_be_a = 8'd0;
        mem_resp_a = 1'b0; mem_rdata_a = 32'd0;
        ch_read_b = 4'd0; ch_write_b = 4'd0; ch_address_b = 128'd0; ch_wdata_b = 128'd0; ch_be_b = 16'd0;
        mem_resp_b = 1'b0; mem_rdata_b = 32'd0;
        repeat (2) @(negedge clk);
        check("reset a", outs_a(), 128'd0);
        check("reset b", {ch_resp_b, ch_rdata_b, mem_read_b, mem_write_b, mem_address_b, tout_b},
              128'd0);
        rst = 1'b0;

        // mem_resp while idle must be ignored
        mem_resp_a = 1'b1; mem_rdata_a = 32'hFFFF_FFFF;
        @(negedge clk);
        mem_resp_a = 1'b0;
        @(negedge clk);
        check("stray mem_resp", outs_a(), 128'd0);

        for (int k = 0; k < 7; k++) begin
            run_vec(vecs[k], k);
        end

        // Round-robin: last vector served ch1, so the pointer sits at ch0
        cnt0 = 0; cnt1 = 0;
        ch_read_a = 2'b11;
        ch_address_a = {32'h0000_2000, 32'h0000_1000};
        for (int t = 0; t < 4; t++) begin
            wait_strobe_a($sformatf("rr%0d", t));
            check($sformatf("rr%0d addr", t), {96'd0, mem_address_a},
                  {96'd0, (rr_exp[t] == 2'b01) ? 32'h0000_1000 : 32'h0000_2000});
            mem_resp_a = 1'b1; mem_rdata_a = 32'h0000_0100 + 32'(t);
            @(negedge clk);
            mem_resp_a = 1'b0;
            check($sformatf("rr%0d resp", t), {126'd0, ch_resp_a}, {126'd0, rr_exp[t]});
            check($sformatf("rr%0d rdata", t), {96'd0, ch_rdata_a}, {96'd0, 32'h0000_0100 + 32'(t)});
            cnt0 += int'(ch_resp_a[0]);
            cnt1 += int'(ch_resp_a[1]);
        end
        ch_read_a = 2'b00;
        check("rr ch0 count", 128'(cnt0), 128'd2);
        check("rr ch1 count", 128'(cnt1), 128'd2);
        @(negedge clk);
        check("rr idle", outs_a(), 128'd0);

        // Fixed priority: ch1 beats ch3 until ch1 drops its request
        ch_address_b = {32'h0000_0100, 32'h0000_00C0, 32'h0000_0080, 32'h0000_0040};
        ch_read_b = 4'b1010;
        for (int t = 0; t < 3; t++) begin
            wait_strobe_b($sformatf("fp%0d", t));
            check($sformatf("fp%0d addr", t), {96'd0, mem_address_b},
                  {96'd0, (t < 2) ? 32'h0000_0080 : 32'h0000_0100});
            mem_resp_b = 1'b1; mem_rdata_b = 32'hB000_0000 + 32'(t);
            @(negedge clk);
            mem_resp_b = 1'b0;
            check($sformatf("fp%0d resp", t), {124'd0, ch_resp_b},
                  {124'd0, (t < 2) ? 4'b0010 : 4'b1000});
            check($sformatf("fp%0d rdata", t), {96'd0, ch_rdata_b}, {96'd0, 32'hB000_0000 + 32'(t)});
            if (t == 1) ch_read_b = 4'b1000;
        end
        ch_read_b = 4'b0000;
        @(negedge clk);
        check("fp idle", {124'd0, ch_resp_b}, 128'd0);

        // Reset in the 2nd BUSY cycle aborts silently; held request is re-granted
        ch_read_a = 2'b01; ch_address_a = 64'h0000_0000_0000_0500;
        @(negedge clk);
        check("rst busy1", {126'd0, mem_read_a, mem_write_a}, 128'd2);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst outputs", outs_a(), 128'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst regrant", {126'd0, mem_read_a, mem_write_a}, 128'd2);
        check("rst regrant addr", {96'd0, mem_address_a}, 128'h500);
        mem_resp_a = 1'b1; mem_rdata_a = 32'h0000_600D;
        @(negedge clk);
        mem_resp_a = 1'b0;
        check("rst resp", {126'd0, ch_resp_a}, 128'd1);
        check("rst rdata", {96'd0, ch_rdata_a}, 128'h600D);
        check("rst tout", {127'd0, tout_a}, 128'd0);
        ch_read_a = 2'b00;
        @(negedge clk);
        check("final idle", outs_a(), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_mem_arbiter.md
PIPE_MEM_ARBITER -- requirements
Module: pipe_mem_arbiter

Interface
REQ-001 Parameter NUM_CH SHALL exist: default 2; number of requesting channels, legal range 2..8.
REQ-002 Parameter ADDR_W SHALL exist: default 32; address width.
REQ-003 Parameter DATA_W SHALL exist: default 32; data width, multiple of 8; BE_W = DATA_W/8.
REQ-004 Parameter RR SHALL exist: default 1; 1 = round-robin, 0 = fixed priority with lowest index winning.
REQ-005 Parameter TIMEOUT SHALL exist: default 0; maximum BUSY cycles before abort; 0 disables the watchdog.
REQ-006 Port clk  in  1: the single clock; all state updates on its rising edge.
REQ-007 Port rst  in  1: reset, synchronous and active-high.
REQ-008 Port ch_read  in  NUM_CH: per-channel read request, held until that channel's ch_resp.
REQ-009 Port ch_write  in  NUM_CH: per-channel write request, held until that channel's ch_resp.
REQ-010 Port ch_address  in  NUM_CH*ADDR_W: per-channel address; channel i occupies slice i.
REQ-011 Port ch_wdata  in  NUM_CH*DATA_W: per-channel write data.
REQ-012 Port ch_byte_enable  in  NUM_CH*BE_W: per-channel byte enables.
REQ-013 Port ch_resp  out  NUM_CH: one-cycle completion pulse, one-hot or zero.
REQ-014 Port ch_rdata  out  DATA_W: read data shared by all channels; valid only while a ch_resp bit is high.
REQ-015 Port mem_read, mem_write  out  1 each: downstream request strobes.
REQ-016 Port mem_address  out  ADDR_W, mem_wdata  out  DATA_W, mem_byte_enable  out  BE_W: downstream request fields.
REQ-017 Port mem_resp  in  1, mem_rdata  in  DATA_W: downstream completion and read data.
REQ-018 Port timeout_err  out  1: one-cycle pulse when the watchdog aborts a transaction.

Function
REQ-019 The block SHALL implement FSM states IDLE, BUSY and DONE.
REQ-020 A channel's request SHALL be defined as ch_read[i] OR ch_write[i].
REQ-021 IDLE: if any request is present, the block SHALL choose grant g per the policy, latch g, op, address, wdata and byte_enable, and go to BUSY; otherwise it SHALL stay in IDLE.
REQ-022 RR=1: the search SHALL start at pointer p and wrap modulo NUM_CH.
REQ-023 RR=1: on entering DONE, p SHALL become (g+1) mod NUM_CH.
REQ-024 RR=0: p SHALL be unused.
REQ-025 If both ch_read[g] and ch_write[g] are high, the operation SHALL be treated as a write.
REQ-026 BUSY: exactly one of mem_read or mem_write SHALL be high, and all mem_* fields SHALL be driven from the latched values, stable for the whole state.
REQ-027 A change on ch_* inputs during BUSY SHALL NOT affect the mem_* outputs.
REQ-028 BUSY with mem_resp=1: the block SHALL latch mem_rdata (zero for writes) and go to DONE; mem_read and mem_write SHALL be 0 from the next cycle.
REQ-029 DONE: ch_resp[g]=1 and ch_rdata = the latched data for exactly one cycle, then the block SHALL return to IDLE.
REQ-030 Requests SHALL NOT be sampled in DONE, so a requester dropping its request on ch_resp is never re-granted.
REQ-031 Latency SHALL be: request sampled in IDLE at edge k gives mem strobe high in cycle k+1; mem_resp in cycle m gives ch_resp in cycle m+1; minimum request-to-resp is 2 cycles.
REQ-032 Watchdog (TIMEOUT>0): a counter SHALL clear on entering BUSY and increment each BUSY cycle.
REQ-033 When the watchdog counter reaches TIMEOUT with no mem_resp, the block SHALL go to DONE with latched data 0 and pulse timeout_err together with ch_resp[g].
REQ-034 If mem_resp coincides with the timeout cycle, mem_resp SHALL win and timeout_err SHALL stay 0.
REQ-035 mem_resp outside BUSY SHALL be ignored.
REQ-036 ch_rdata SHALL be 0 whenever ch_resp is all-zero.

Reset
REQ-037 While rst=1 at a clock edge, the block SHALL enter IDLE and set p=0, the watchdog counter to 0, all latches to 0, and every output to 0.
REQ-038 Reset SHALL override any state, including mid-BUSY or mid-DONE; the aborted transaction SHALL NOT produce ch_resp or timeout_err.
REQ-039 After reset the block SHALL arbitrate normally from the first cycle with rst=0.

Verification
REQ-040 Single read: ch0 read addr 0x100, mem_resp one cycle after mem_read with rdata 0xDEADBEEF -> ch_resp=2'b01 for one cycle, ch_rdata=0xDEADBEEF, total 3 cycles.
REQ-041 Round-robin, NUM_CH=2: ch0 and ch1 both requesting continuously -> grants alternate 0,1,0,1; each channel completes exactly once per two transactions.
REQ-042 Fixed priority, RR=0, NUM_CH=4: ch1 and ch3 requesting -> ch1 is served first; ch3 is served only after ch1 drops its request.
REQ-043 Write with read+write both high on ch1, addr 0x20, wdata 0x12345678, be 4'b0011 -> mem_write=1, mem_read=0, fields match and stay stable until mem_resp, ch_rdata=0.
REQ-044 Timeout, TIMEOUT=4, mem_resp never asserted -> after 4 BUSY cycles ch_resp[g] and timeout_err pulse together, ch_rdata=0; a second run with mem_resp in the 4th cycle -> timeout_err=0.
REQ-045 rst asserted in the 2nd BUSY cycle -> next cycle all outputs 0, no ch_resp; a request held through reset is re-granted with mem strobe one cycle after rst deasserts.
